// File: rtl/sfl_pkg.sv
// Shared types and constants for the serial frame loader and its UART receiver.
package sfl_pkg;
  localparam logic [7:0] CMD_BASE         = 8'hA0;
  localparam logic [7:0] CMD_MASK         = 8'hFC;
  localparam int         FRAME_WORDS      = 1024;
  localparam int         SLOT_BITS        = 2;
  localparam int         CLKS_PER_BIT_DEF = 868;

  typedef enum logic [2:0] {
    S_IDLE, S_HI, S_LO, S_WRREQ, S_CKSUM, S_FINISH, S_FAIL
  } ld_state_t;

  typedef enum logic [1:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP
  } rx_state_t;
endpackage

// File: rtl/serial_frame_loader_if.sv
// Write port into the shared frame RAM; the loader is the master, the arbiter/RAM the slave.
interface serial_frame_loader_if #(parameter int ADDR_BITS = 12);
  logic                 ramReq;
  logic                 ramGnt;
  logic                 ramEnable;
  logic                 ramWrite;
  logic [ADDR_BITS-1:0] ramAddr;
  logic [15:0]          ramDataIn;

  modport master (output ramReq, ramEnable, ramWrite, ramAddr, ramDataIn, input ramGnt);
  modport slave  (input ramReq, ramEnable, ramWrite, ramAddr, ramDataIn, output ramGnt);
endinterface

// File: rtl/serial_frame_loader_uart_rx_byte.sv
// 8N1 byte receiver: 2-flop synchronizer, mid-bit sampling, one-cycle byte/framing-error pulses.
module uart_rx_byte import sfl_pkg::*; #(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       frame_err
);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

  logic            s1_q, s2_q, prev_q;
  rx_state_t       st_q, st_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      sh_q, sh_d, byte_q, byte_d;
  logic            vld_q, vld_d, ferr_q, ferr_d;

  // Sampling sequence: detect the falling edge, confirm the start bit, shift 8 bits, check the stop bit.
  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q + 1'b1;
    bit_d  = bit_q;
    sh_d   = sh_q;
    byte_d = byte_q;
    vld_d  = 1'b0;
    ferr_d = 1'b0;
    unique case (st_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (prev_q && !s2_q) st_d = RX_START;
      end
      RX_START: if (cnt_q == HALF) begin
        cnt_d = '0;
        bit_d = '0;
        st_d  = s2_q ? RX_IDLE : RX_DATA;  // glitch: abort without reporting
      end
      RX_DATA: if (cnt_q == FULL) begin
        cnt_d = '0;
        sh_d  = {s2_q, sh_q[7:1]};
        bit_d = bit_q + 1'b1;
        if (bit_q == 3'd7) st_d = RX_STOP;
      end
      RX_STOP: if (cnt_q == FULL) begin
        cnt_d  = '0;
        st_d   = RX_IDLE;
        byte_d = sh_q;
        vld_d  = s2_q;
        ferr_d = !s2_q;
      end
      default: st_d = RX_IDLE;
    endcase
  end

  // Synchronizer and receiver state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b1; s2_q <= 1'b1; prev_q <= 1'b1;
      st_q <= RX_IDLE; cnt_q <= '0; bit_q <= '0; sh_q <= '0; byte_q <= '0;
      vld_q <= 1'b0; ferr_q <= 1'b0;
    end else begin
      s1_q <= rx; s2_q <= s1_q; prev_q <= s2_q;
      st_q <= st_d; cnt_q <= cnt_d; bit_q <= bit_d; sh_q <= sh_d; byte_q <= byte_d;
      vld_q <= vld_d; ferr_q <= ferr_d;
    end
  end

  assign byte_valid = vld_q;
  assign rx_byte    = byte_q;
  assign frame_err  = ferr_q;
endmodule

// File: rtl/serial_frame_loader.sv
// Loads checksummed frames from the UART into one slot of the shared frame RAM.
module serial_frame_loader import sfl_pkg::*; #(
  parameter int CLKS_PER_BIT  = CLKS_PER_BIT_DEF,
  parameter int RAM_ADDR_BITS = SLOT_BITS + $clog2(FRAME_WORDS)
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  IN_SERIAL_RX,
  serial_frame_loader_if.master ram,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [1:0]            loadedSlot
);
  localparam int IDX_W = RAM_ADDR_BITS - SLOT_BITS;

  logic       byte_valid, frame_err;
  logic [7:0] rx_byte;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk(CLK), .rst(RESET), .rx(IN_SERIAL_RX),
    .byte_valid(byte_valid), .rx_byte(rx_byte), .frame_err(frame_err)
  );

  ld_state_t        st_q, st_d;
  logic [1:0]       slot_q, slot_d, loaded_q, loaded_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [15:0]      data_q, data_d;
  logic [7:0]       cks_q, cks_d;
  logic             busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic             req, wr;

  assign req = (st_q == S_WRREQ);
  assign wr  = req && ram.ramGnt;

  // Loader next state; status flags change on entry to FINISH/FAIL so they land one cycle after the byte.
  always_comb begin
    st_d     = st_q;
    slot_d   = slot_q;
    idx_d    = idx_q;
    data_d   = data_q;
    cks_d    = cks_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = err_q;
    loaded_d = loaded_q;
    unique case (st_q)
      S_IDLE: if (byte_valid && ((rx_byte & CMD_MASK) == CMD_BASE)) begin
        slot_d = rx_byte[1:0];
        idx_d  = '0;
        cks_d  = '0;
        err_d  = 1'b0;
        busy_d = 1'b1;
        st_d   = S_HI;
      end
      S_HI: if (frame_err) st_d = S_FAIL;
        else if (byte_valid) begin
          data_d[15:8] = rx_byte;
          cks_d        = cks_q ^ rx_byte;
          st_d         = S_LO;
        end
      S_LO: if (frame_err) st_d = S_FAIL;
        else if (byte_valid) begin
          data_d[7:0] = rx_byte;
          cks_d       = cks_q ^ rx_byte;
          st_d        = S_WRREQ;
        end
      S_WRREQ: begin
        if (wr) begin
          idx_d = idx_q + 1'b1;
          st_d  = (&idx_q) ? S_CKSUM : S_HI;
        end
        // A byte arriving before the grant means the host outran the RAM; the write (if granted now) still happens.
        if (byte_valid || frame_err) st_d = S_FAIL;
      end
      S_CKSUM: if (frame_err) st_d = S_FAIL;
        else if (byte_valid) st_d = (rx_byte == cks_q) ? S_FINISH : S_FAIL;
      S_FINISH: st_d = S_IDLE;
      S_FAIL:   st_d = S_IDLE;
      default:  st_d = S_IDLE;
    endcase
    if (st_d == S_FINISH) begin
      done_d   = 1'b1;
      busy_d   = 1'b0;
      loaded_d = slot_q;
    end
    if (st_d == S_FAIL && st_q != S_FAIL) begin
      err_d  = 1'b1;
      busy_d = 1'b0;
    end
  end

  // Loader state registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      st_q <= S_IDLE; slot_q <= '0; loaded_q <= '0; idx_q <= '0;
      data_q <= '0; cks_q <= '0; busy_q <= 1'b0; done_q <= 1'b0; err_q <= 1'b0;
    end else begin
      st_q <= st_d; slot_q <= slot_d; loaded_q <= loaded_d; idx_q <= idx_d;
      data_q <= data_d; cks_q <= cks_d; busy_q <= busy_d; done_q <= done_d; err_q <= err_d;
    end
  end

  assign ram.ramReq    = req;
  assign ram.ramEnable = wr;
  assign ram.ramWrite  = wr;
  assign ram.ramAddr   = {slot_q, idx_q};
  assign ram.ramDataIn = data_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign loadedSlot    = loaded_q;
endmodule

// File: tb/tb_serial_frame_loader.sv
// Directed bench for serial_frame_loader with a reduced 16-word frame (RAM_ADDR_BITS=6).
module tb_serial_frame_loader;
  import sfl_pkg::*;

  localparam int CPB = 16;
  localparam int AB  = 6;
  localparam int NW  = 1 << (AB - 2);

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       rx = 1'b1;
  logic       busy, done, err;
  logic [1:0] loadedSlot;

  serial_frame_loader_if #(.ADDR_BITS(AB)) ram_if ();

  serial_frame_loader #(.CLKS_PER_BIT(CPB), .RAM_ADDR_BITS(AB)) dut (
    .CLK(CLK), .RESET(RESET), .IN_SERIAL_RX(rx), .ram(ram_if),
    .busy(busy), .done(done), .err(err), .loadedSlot(loadedSlot)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Arbiter model: gd==0 grants always, gd>0 grants after gd+1 request cycles, gd<0 never grants.
  int gd = 0;
  int age = 0;
  initial begin
    ram_if.ramGnt = 1'b1;
    forever begin
      @(posedge CLK); #1;
      if (ram_if.ramReq) age++; else age = 0;
      ram_if.ramGnt = (gd == 0) || (gd > 0 && age > gd);
    end
  end

  // RAM model and protocol monitor, sampled mid-cycle.
  logic [15:0]   mem [64];
  int            stamp [64];
  int            wr_cnt = 0, done_cnt = 0, done_busy_bad = 0, en_bad = 0, stab_bad = 0, req_cyc = 0;
  logic          req_prev = 1'b0;
  logic [AB-1:0] a0;
  logic [15:0]   d0;
  always @(negedge CLK) begin
    if (!RESET) begin
      if (ram_if.ramEnable !== (ram_if.ramReq && ram_if.ramGnt) ||
          ram_if.ramWrite  !== (ram_if.ramReq && ram_if.ramGnt)) en_bad++;
      if (ram_if.ramReq) begin
        req_cyc++;
        if (req_prev && (ram_if.ramAddr !== a0 || ram_if.ramDataIn !== d0)) stab_bad++;
        a0 = ram_if.ramAddr;
        d0 = ram_if.ramDataIn;
      end
      if (ram_if.ramEnable && ram_if.ramWrite) begin
        wr_cnt++;
        mem[ram_if.ramAddr]   = ram_if.ramDataIn;
        stamp[ram_if.ramAddr] = wr_cnt;
      end
      if (done) begin
        done_cnt++;
        if (busy) done_busy_bad++;
      end
    end
    req_prev = ram_if.ramReq && !RESET;
  end

  initial begin
    #3_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  function automatic logic [15:0] word_of(input int i, input bit alt, input logic [7:0] add);
    logic [7:0] hi, lo;
    hi = 8'(i) + add;
    lo = alt ? 8'(i * 37 + 5) : (hi ^ 8'h5A);
    return {hi, lo};
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit bad_stop);
    @(negedge CLK); rx = 1'b0;
    repeat (CPB) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge CLK);
    end
    rx = !bad_stop;
    repeat (CPB) @(negedge CLK);
    rx = 1'b1;
    repeat (4) @(negedge CLK);
  endtask

  task automatic send_words(input int first, input int n, input bit alt, input logic [7:0] add);
    logic [15:0] w;
    for (int i = first; i < first + n; i++) begin
      w = word_of(i, alt, add);
      send_byte(w[15:8], 1'b0);
      send_byte(w[7:0], 1'b0);
    end
  endtask

  task automatic send_frame(input logic [1:0] slot, input logic [7:0] flip, input bit alt, input logic [7:0] add);
    logic [7:0]  cks;
    logic [15:0] w;
    cks = 8'h00;
    send_byte(CMD_BASE | {6'd0, slot}, 1'b0);
    for (int i = 0; i < NW; i++) begin
      w = word_of(i, alt, add);
      send_byte(w[15:8], 1'b0);
      send_byte(w[7:0], 1'b0);
      cks = cks ^ w[15:8] ^ w[7:0];
    end
    send_byte(cks ^ flip, 1'b0);
    repeat (10) @(negedge CLK);
  endtask

  typedef struct {
    logic [1:0] slot;
    logic [7:0] flip;
    int         gd;
    bit         alt;
    logic [7:0] add;
    bit         exp_done;
    bit         exp_err;
    logic [1:0] exp_ld;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int nz, bad, wbase, dbase, rbase, sbase, ebase, bbase, a;
    vecs[0] = '{2'd2, 8'h00,  0, 1'b0, 8'h00, 1'b1, 1'b0, 2'd2};
    vecs[1] = '{2'd3, 8'h01,  0, 1'b0, 8'h00, 1'b0, 1'b1, 2'd2};
    vecs[2] = '{2'd0, 8'h00, 50, 1'b0, 8'h00, 1'b1, 1'b0, 2'd0};
    vecs[3] = '{2'd3, 8'h00,  3, 1'b1, 8'h40, 1'b1, 1'b0, 2'd3};
    vecs[4] = '{2'd1, 8'h80,  1, 1'b1, 8'h20, 1'b0, 1'b1, 2'd3};

    // Reset values, then a quiet line for 1000 cycles.
    repeat (5) @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_loaded", loadedSlot, 0);
    check("rst_req", ram_if.ramReq, 0);
    check("rst_en", ram_if.ramEnable, 0);
    check("rst_wr", ram_if.ramWrite, 0);
    check("rst_addr", ram_if.ramAddr, 0);
    check("rst_data", ram_if.ramDataIn, 0);
    nz = 0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge CLK);
      if (busy || done || err || loadedSlot != 0 || ram_if.ramReq || ram_if.ramEnable ||
          ram_if.ramWrite || ram_if.ramAddr != 0 || ram_if.ramDataIn != 0) nz++;
    end
    check("idle_quiet", nz, 0);

    // Whole-frame loads from the table.
    for (int v = 0; v < 5; v++) begin
      gd = vecs[v].gd;
      repeat (3) @(negedge CLK);
      wbase = wr_cnt; dbase = done_cnt; rbase = req_cyc; sbase = stab_bad; ebase = en_bad; bbase = done_busy_bad;
      send_frame(vecs[v].slot, vecs[v].flip, vecs[v].alt, vecs[v].add);
      check($sformatf("v%0d_writes", v), wr_cnt - wbase, NW);
      check($sformatf("v%0d_done", v), done_cnt - dbase, vecs[v].exp_done);
      check($sformatf("v%0d_err", v), err, vecs[v].exp_err);
      check($sformatf("v%0d_busy", v), busy, 0);
      check($sformatf("v%0d_loaded", v), loadedSlot, vecs[v].exp_ld);
      check($sformatf("v%0d_reqlen", v), req_cyc - rbase, NW * (vecs[v].gd + 1));
      check($sformatf("v%0d_stable", v), stab_bad - sbase, 0);
      check($sformatf("v%0d_en", v), en_bad - ebase, 0);
      check($sformatf("v%0d_done_busy", v), done_busy_bad - bbase, 0);
      bad = 0;
      for (int i = 0; i < NW; i++) begin
        a = (int'(vecs[v].slot) << (AB - 2)) + i;
        if (stamp[a] <= wbase || mem[a] !== word_of(i, vecs[v].alt, vecs[v].add)) bad++;
      end
      check($sformatf("v%0d_data", v), bad, 0);
    end

    // Overrun: grant withheld while the next byte arrives.
    gd = -1;
    repeat (3) @(negedge CLK);
    wbase = wr_cnt;
    send_byte(8'hA1, 1'b0);
    check("ovr_busy_set", busy, 1);
    check("ovr_err_clr", err, 0);
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    check("ovr_req_held", ram_if.ramReq, 1);
    check("ovr_addr", ram_if.ramAddr, 6'h10);
    check("ovr_data", ram_if.ramDataIn, 16'h1234);
    send_byte(8'h56, 1'b0);
    check("ovr_err", err, 1);
    check("ovr_busy", busy, 0);
    check("ovr_req_drop", ram_if.ramReq, 0);
    gd = 0;
    repeat (20) @(negedge CLK);
    check("ovr_no_write", wr_cnt - wbase, 0);

    // Framing error on word 10's low byte, then a stray byte and a misframed command in IDLE.
    wbase = wr_cnt;
    send_byte(8'hA0, 1'b0);
    send_words(0, 10, 1'b0, 8'h00);
    send_byte(8'h0A, 1'b0);
    send_byte(8'h0A ^ 8'h5A, 1'b1);
    check("fe_err", err, 1);
    check("fe_busy", busy, 0);
    check("fe_writes", wr_cnt - wbase, 10);
    send_byte(8'h55, 1'b0);
    check("stray_busy", busy, 0);
    check("stray_err_kept", err, 1);
    send_byte(8'hA2, 1'b1);
    check("idle_fe_busy", busy, 0);
    check("idle_fe_err_kept", err, 1);
    check("idle_no_write", wr_cnt - wbase, 10);

    // Reset in the middle of a slot-1 load.
    wbase = wr_cnt;
    send_byte(8'hA1, 1'b0);
    send_words(0, 6, 1'b0, 8'h00);
    send_byte(8'h06, 1'b0);
    check("mid_writes", wr_cnt - wbase, 6);
    RESET = 1'b1;
    @(negedge CLK);
    check("mid_rst_req", ram_if.ramReq, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_err", err, 0);
    check("mid_rst_loaded", loadedSlot, 0);
    @(negedge CLK);
    RESET = 1'b0;
    wbase = wr_cnt;
    send_byte(8'h06 ^ 8'h5A, 1'b0);
    send_words(7, 3, 1'b0, 8'h00);
    check("post_rst_writes", wr_cnt - wbase, 0);
    check("post_rst_busy", busy, 0);
    dbase = done_cnt;
    wbase = wr_cnt;
    send_frame(2'd1, 8'h00, 1'b0, 8'h00);
    check("reload_done", done_cnt - dbase, 1);
    check("reload_loaded", loadedSlot, 1);
    check("reload_err", err, 0);
    check("reload_writes", wr_cnt - wbase, NW);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
